hls_ap_controller: RTL

//  Wishbone-mapped sequencer for one HLS kernel with ap_ctrl_hs block protocol. Software starts runs via

---
 rtl/hls_ap_controller.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/hls_ap_controller.sv
// Wishbone-mapped ap_ctrl_hs sequencer: starts one HLS kernel, times each run, counts completions, raises irq.
// Optional watchdog enabled by defining HLS_AP_CONTROLLER_TIMEOUT_EN.
module hls_ap_controller #(
  parameter int          WB_ADR_WIDTH   = 8,
  parameter int          WB_DAT_WIDTH   = 64,
  parameter int          WB_SEL_WIDTH   = WB_DAT_WIDTH / 8,
  parameter int          COUNT_WIDTH    = 32,
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter logic [63:0] CORE_ID        = 64'h0000_0000_4C53_4150
) (
  input  logic                    resetn,
  input  logic                    clk,
  input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
  input  logic                    s_wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
  input  logic                    s_wb_stb_i,
  output logic                    s_wb_ack_o,
  output logic                    m_ap_start,
  input  logic                    s_ap_ready,
  input  logic                    s_ap_done,
  input  logic                    s_ap_idle,
  output logic                    irq
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_START    = 2'd1,
    ST_WAIT     = 2'd2,
    ST_COMPLETE = 2'd3
  } state_t;

  state_t                 state_r, state_nx;
  logic                   m_ap_start_r, irq_r;
  logic                   auto_restart_r, irq_en_r, done_r;
  logic                   auto_restart_nx, irq_en_nx, done_nx, irq_nx;
  logic [COUNT_WIDTH-1:0] count_r, cycles_r, runs_r;
  logic                   ctrl_wr_s, status_wr_s, start_req_s, complete_s;
  logic                   run_active_s, busy_s;
  logic                   timeout_hit_s, timeout_nx_s, timeout_s;
  logic [WB_DAT_WIDTH-1:0] rd_s;
  logic                   unused_s;

  // Control/status bits all live in byte lane 0, so only sel[0] gates their writes.
  assign ctrl_wr_s    = s_wb_stb_i && s_wb_we_i && s_wb_sel_i[0] && (s_wb_adr_i[2:0] == 3'd0);
  assign status_wr_s  = s_wb_stb_i && s_wb_we_i && s_wb_sel_i[0] && (s_wb_adr_i[2:0] == 3'd1);
  assign start_req_s  = ctrl_wr_s && s_wb_dat_i[0];
  assign run_active_s = (state_r == ST_START) || (state_r == ST_WAIT);
  assign busy_s       = (state_r != ST_IDLE);
  assign unused_s     = ^{s_wb_adr_i[WB_ADR_WIDTH-1:3], s_wb_dat_i[WB_DAT_WIDTH-1:3],
                          s_wb_sel_i[WB_SEL_WIDTH-1:1]};

`ifdef HLS_AP_CONTROLLER_TIMEOUT_EN
  logic [31:0] wd_r;
  logic        timeout_r;

  assign timeout_hit_s = run_active_s && (wd_r == 32'(TIMEOUT_CYCLES - 1));
  assign timeout_s     = timeout_r;

  // Sticky timeout flag: a new expiry takes priority over a software clear.
  always_comb begin
    timeout_nx_s = timeout_r;
    if (timeout_hit_s) begin
      timeout_nx_s = 1'b1;
    end else if (status_wr_s && s_wb_dat_i[3]) begin
      timeout_nx_s = 1'b0;
    end else begin
      timeout_nx_s = timeout_r;
    end
  end

  // Watchdog counter restarts with every run and advances while the kernel is owed a result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_r      <= 32'd0;
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= timeout_nx_s;
      if ((state_nx == ST_START) && !run_active_s) begin
        wd_r <= 32'd0;
      end else if (run_active_s) begin
        wd_r <= wd_r + 32'd1;
      end
    end
  end
`else
  localparam int unused_timeout_lp = TIMEOUT_CYCLES;
  assign timeout_hit_s = 1'b0;
  assign timeout_nx_s  = 1'b0;
  assign timeout_s     = 1'b0;
`endif

  // Next-state and next-register values; irq follows the next values so it tracks writes without lag.
  always_comb begin
    state_nx        = state_r;
    complete_s      = 1'b0;
    auto_restart_nx = auto_restart_r;
    irq_en_nx       = irq_en_r;
    done_nx         = done_r;
    case (state_r)
      ST_IDLE: begin
        if (start_req_s) state_nx = ST_START;
        else             state_nx = ST_IDLE;
      end
      ST_START: begin
        if (s_ap_ready && s_ap_done) state_nx = ST_COMPLETE;
        else if (s_ap_ready)         state_nx = ST_WAIT;
        else                         state_nx = ST_START;
      end
      ST_WAIT: begin
        if (s_ap_done) state_nx = ST_COMPLETE;
        else           state_nx = ST_WAIT;
      end
      ST_COMPLETE: begin
        complete_s = 1'b1;
        if (auto_restart_r) state_nx = ST_START;
        else                state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (timeout_hit_s) begin
      state_nx        = ST_IDLE;
      auto_restart_nx = 1'b0;
    end else if (ctrl_wr_s) begin
      auto_restart_nx = s_wb_dat_i[1];
    end else begin
      auto_restart_nx = auto_restart_r;
    end
    if (ctrl_wr_s) irq_en_nx = s_wb_dat_i[2];
    else           irq_en_nx = irq_en_r;
    if (complete_s)                          done_nx = 1'b1;
    else if (status_wr_s && s_wb_dat_i[1])   done_nx = 1'b0;
    else                                     done_nx = done_r;
    irq_nx = irq_en_nx && (done_nx || timeout_nx_s);
  end

  // Main state, control registers, run counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r        <= ST_IDLE;
      m_ap_start_r   <= 1'b0;
      irq_r          <= 1'b0;
      auto_restart_r <= 1'b0;
      irq_en_r       <= 1'b0;
      done_r         <= 1'b0;
      count_r        <= {COUNT_WIDTH{1'b0}};
      cycles_r       <= {COUNT_WIDTH{1'b0}};
      runs_r         <= {COUNT_WIDTH{1'b0}};
    end else begin
      state_r        <= state_nx;
      m_ap_start_r   <= (state_nx == ST_START);
      irq_r          <= irq_nx;
      auto_restart_r <= auto_restart_nx;
      irq_en_r       <= irq_en_nx;
      done_r         <= done_nx;
      if (complete_s) begin
        runs_r   <= runs_r + COUNT_WIDTH'(1);
        cycles_r <= count_r;
      end
      if ((state_nx == ST_START) && !run_active_s) begin
        count_r <= {COUNT_WIDTH{1'b0}};
      end else if (run_active_s && (count_r != {COUNT_WIDTH{1'b1}})) begin
        count_r <= count_r + COUNT_WIDTH'(1);
      end
    end
  end

  // Zero-wait combinational register read.
  always_comb begin
    rd_s = {WB_DAT_WIDTH{1'b0}};
    case (s_wb_adr_i[2:0])
      3'd0:    rd_s = WB_DAT_WIDTH'({irq_en_r, auto_restart_r, 1'b0});
      3'd1:    rd_s = WB_DAT_WIDTH'({timeout_s, s_ap_idle, done_r, busy_s});
      3'd2:    rd_s = WB_DAT_WIDTH'(cycles_r);
      3'd3:    rd_s = WB_DAT_WIDTH'(runs_r);
      3'd4:    rd_s = WB_DAT_WIDTH'(CORE_ID);
      default: rd_s = {WB_DAT_WIDTH{1'b0}};
    endcase
  end

  assign s_wb_dat_o = rd_s;
  assign s_wb_ack_o = s_wb_stb_i;
  assign m_ap_start = m_ap_start_r;
  assign irq        = irq_r;

endmodule
